or1k_perf_counters: RTL and testbench

OR1K_PERF_COUNTERS -- requirements
Module: or1k_perf_counters

---
 rtl/or1k_perf_counters_pkg.sv | 41 ++++
 rtl/or1k_pcu_counter.sv | 96 +++++++++
 rtl/or1k_perf_counters.sv | 139 +++++++++++++
 tb/tb_or1k_perf_counters.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_perf_counters_pkg.sv
// Shared definitions for the OR1K performance counter unit.
// Holds SPR offset map, MODE/GCTL bit positions and a popcount helper.
// No logic or state; imported by the counter slice and the top.
package or1k_perf_counters_pkg;

    // SPR offset groups selected by offset[4:3]
    typedef enum logic [1:0] {
        GRP_CNTLO = 2'd0,
        GRP_MODE  = 2'd1,
        GRP_CNTHI = 2'd2,
        GRP_MISC  = 2'd3
    } grp_e;

    localparam logic [4:0] OFS_CNTLO = 5'd0;
    localparam logic [4:0] OFS_MODE  = 5'd8;
    localparam logic [4:0] OFS_CNTHI = 5'd16;
    localparam logic [4:0] OFS_OVF   = 5'd24;
    localparam logic [4:0] OFS_GCTL  = 5'd25;

    // MODE register bit positions
    localparam int MODE_CP       = 0;
    localparam int MODE_CISM     = 1;
    localparam int MODE_CIUM     = 2;
    localparam int MODE_MASK_LSB = 3;
    localparam int MODE_OVIE     = 31;

    // GCTL register bit positions
    localparam int GCTL_GEN = 0;
    localparam int GCTL_FOO = 1;

    // Number of set bits in a 32-bit vector
    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/or1k_pcu_counter.sv
// One counter slice: event counter, MODE register, high-word shadow, overflow detect.
// Counter and shadow update on the edge after the strobe; ovf_set is combinational.
// No backpressure; SPR writes always take priority over the increment.
module or1k_pcu_counter
    import or1k_perf_counters_pkg::*;
#(
    parameter int COUNTER_WIDTH = 48,
    parameter int NUM_EVENTS    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  sys,
    input  logic [NUM_EVENTS-1:0] events,
    input  logic                  mode_we,
    input  logic                  lo_we,
    input  logic                  hi_we,
    input  logic                  lo_re,
    input  logic [31:0]           wdat,
    output logic [31:0]           lo,
    output logic [COUNTER_WIDTH-33:0] shi,
    output logic [31:0]           mode_rd,
    output logic                  ovie,
    output logic                  ovf_set
);

    localparam int HW = COUNTER_WIDTH - 32;

    logic                     cism;
    logic                     cium;
    logic [NUM_EVENTS-1:0]    mask;
    logic [COUNTER_WIDTH-1:0] count;
    logic [COUNTER_WIDTH:0]   sum;
    logic [5:0]               inc;
    logic                     active;

    // Increment amount, carry-out and gating; a same-cycle SPR write suppresses overflow
    always_comb begin
        active  = run & ((cism & sys) | (cium & ~sys));
        inc     = popcount32(32'(events & mask));
        sum     = {1'b0, count} + {{(COUNTER_WIDTH - 5){1'b0}}, inc};
        ovf_set = active & ~lo_we & ~hi_we & sum[COUNTER_WIDTH];
    end

    // MODE register; CP is constant and not stored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cism <= 1'b0;
            cium <= 1'b0;
            mask <= '0;
            ovie <= 1'b0;
        end else if (mode_we) begin
            cism <= wdat[MODE_CISM];
            cium <= wdat[MODE_CIUM];
            mask <= wdat[NUM_EVENTS+MODE_MASK_LSB-1:MODE_MASK_LSB];
            ovie <= wdat[MODE_OVIE];
        end
    end

    // Counter: SPR writes win over the increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (lo_we) begin
            count[31:0] <= wdat;
        end else if (hi_we) begin
            count[COUNTER_WIDTH-1:32] <= wdat[HW-1:0];
        end else if (active) begin
            count <= sum[COUNTER_WIDTH-1:0];
        end
    end

    // High-word shadow: captured on a low-word read so the later high read is coherent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shi <= '0;
        end else if (hi_we) begin
            shi <= wdat[HW-1:0];
        end else if (lo_re) begin
            shi <= count[COUNTER_WIDTH-1:32];
        end
    end

    // MODE readback image
    always_comb begin
        mode_rd = '0;
        mode_rd[MODE_CP]   = 1'b1;
        mode_rd[MODE_CISM] = cism;
        mode_rd[MODE_CIUM] = cium;
        mode_rd[NUM_EVENTS+MODE_MASK_LSB-1:MODE_MASK_LSB] = mask;
        mode_rd[MODE_OVIE] = ovie;
    end

    assign lo = count[31:0];

endmodule

// File: rtl/or1k_perf_counters.sv
// Performance counter unit top: SPR decode, OVF status, GCTL, interrupt.
// Reads are combinational, writes land on the next edge, irq is one cycle behind OVF.
// No backpressure; ack follows the access strobe, user-mode writes are dropped.
module or1k_perf_counters
    import or1k_perf_counters_pkg::*;
#(
    parameter int NUM_COUNTERS  = 8,
    parameter int COUNTER_WIDTH = 48,
    parameter int NUM_EVENTS    = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spr_access_i,
    input  logic                  spr_we_i,
    input  logic                  spr_re_i,
    input  logic [15:0]           spr_addr_i,
    input  logic [31:0]           spr_dat_i,
    output logic                  spr_bus_ack,
    output logic [31:0]           spr_dat_o,
    input  logic                  spr_sys_mode_i,
    input  logic [NUM_EVENTS-1:0] events_i,
    output logic                  pcu_irq_o
);

    localparam int HW = COUNTER_WIDTH - 32;

    logic [4:0]              ofs;
    grp_e                    grp;
    logic                    wr;
    logic                    rd;
    logic                    gen;
    logic                    foo;
    logic                    run;
    logic [NUM_COUNTERS-1:0] ovf;
    logic [NUM_COUNTERS-1:0] ovf_clr;
    logic [NUM_COUNTERS-1:0] ovf_set;
    logic [NUM_COUNTERS-1:0] ovie;
    logic [NUM_COUNTERS-1:0] sel;
    logic [31:0]             cnt_lo  [NUM_COUNTERS];
    logic [HW-1:0]           cnt_shi [NUM_COUNTERS];
    logic [31:0]             mode_rd [NUM_COUNTERS];
    logic                    unused_addr;

    assign ofs         = spr_addr_i[4:0];
    assign grp         = grp_e'(ofs[4:3]);
    assign wr          = spr_access_i & spr_we_i & spr_sys_mode_i;
    assign rd          = spr_access_i & spr_re_i;
    assign run         = gen & ~(foo & |ovf);
    assign spr_bus_ack = spr_access_i;
    assign ovf_clr     = (wr && ofs == OFS_OVF) ? spr_dat_i[NUM_COUNTERS-1:0] : '0;
    assign unused_addr = ^spr_addr_i[15:5];

    for (genvar n = 0; n < NUM_COUNTERS; n++) begin : g_cnt
        assign sel[n] = (ofs[2:0] == 3'(n));

        or1k_pcu_counter #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .NUM_EVENTS    (NUM_EVENTS)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .sys     (spr_sys_mode_i),
            .events  (events_i),
            .mode_we (wr & (grp == GRP_MODE) & sel[n]),
            .lo_we   (wr & (grp == GRP_CNTLO) & sel[n]),
            .hi_we   (wr & (grp == GRP_CNTHI) & sel[n]),
            .lo_re   (rd & (grp == GRP_CNTLO) & sel[n]),
            .wdat    (spr_dat_i),
            .lo      (cnt_lo[n]),
            .shi     (cnt_shi[n]),
            .mode_rd (mode_rd[n]),
            .ovie    (ovie[n]),
            .ovf_set (ovf_set[n])
        );
    end

    // Sticky overflow status, write-1-to-clear; a same-cycle set beats the clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    // Global control register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen <= 1'b0;
            foo <= 1'b0;
        end else if (wr && ofs == OFS_GCTL) begin
            gen <= spr_dat_i[GCTL_GEN];
            foo <= spr_dat_i[GCTL_FOO];
        end
    end

    // Registered overflow interrupt level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcu_irq_o <= 1'b0;
        end else begin
            pcu_irq_o <= |(ovf & ovie);
        end
    end

    // Read mux; control registers are hidden from user mode
    always_comb begin
        spr_dat_o = '0;
        if (rd) begin
            unique case (grp)
                GRP_CNTLO: begin
                    for (int n = 0; n < NUM_COUNTERS; n++) begin
                        if (sel[n]) spr_dat_o = cnt_lo[n];
                    end
                end
                GRP_MODE: begin
                    for (int n = 0; n < NUM_COUNTERS; n++) begin
                        if (sel[n] && spr_sys_mode_i) spr_dat_o = mode_rd[n];
                    end
                end
                GRP_CNTHI: begin
                    for (int n = 0; n < NUM_COUNTERS; n++) begin
                        if (sel[n]) spr_dat_o = 32'(cnt_shi[n]);
                    end
                end
                GRP_MISC: begin
                    if (spr_sys_mode_i && ofs == OFS_OVF) begin
                        spr_dat_o = 32'(ovf);
                    end else if (spr_sys_mode_i && ofs == OFS_GCTL) begin
                        spr_dat_o = {30'b0, foo, gen};
                    end
                end
                default: spr_dat_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_or1k_perf_counters.sv
// Directed bench for or1k_perf_counters with default parameters (8 x 48-bit, 11 events).
// Inputs change on the falling edge; outputs are sampled 1ns after an edge.
module tb_or1k_perf_counters;

    localparam int NE = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          spr_access_i;
    logic          spr_we_i;
    logic          spr_re_i;
    logic [15:0]   spr_addr_i;
    logic [31:0]   spr_dat_i;
    logic          spr_bus_ack;
    logic [31:0]   spr_dat_o;
    logic          spr_sys_mode_i;
    logic [NE-1:0] events_i;
    logic          pcu_irq_o;

    int n_cmp = 0;
    int n_err = 0;

    or1k_perf_counters #(
        .NUM_COUNTERS  (8),
        .COUNTER_WIDTH (48),
        .NUM_EVENTS    (NE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .spr_access_i   (spr_access_i),
        .spr_we_i       (spr_we_i),
        .spr_re_i       (spr_re_i),
        .spr_addr_i     (spr_addr_i),
        .spr_dat_i      (spr_dat_i),
        .spr_bus_ack    (spr_bus_ack),
        .spr_dat_o      (spr_dat_o),
        .spr_sys_mode_i (spr_sys_mode_i),
        .events_i       (events_i),
        .pcu_irq_o      (pcu_irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic spr_wr(input logic [4:0] ofs, input logic [31:0] d,
                          input logic sys, input logic [NE-1:0] ev);
        @(negedge clk);
        spr_access_i   = 1'b1;
        spr_we_i       = 1'b1;
        spr_addr_i     = {11'h0, ofs};
        spr_dat_i      = d;
        spr_sys_mode_i = sys;
        events_i       = ev;
        #1 check("write_ack", {31'b0, spr_bus_ack}, 32'd1);
        @(posedge clk);
        #1;
        spr_access_i   = 1'b0;
        spr_we_i       = 1'b0;
        spr_dat_i      = '0;
        spr_sys_mode_i = 1'b1;
        events_i       = '0;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] ofs,
                          input logic sys, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge clk);
        spr_access_i   = 1'b1;
        spr_re_i       = 1'b1;
        spr_addr_i     = {11'h0, ofs};
        spr_sys_mode_i = sys;
        #1 d = spr_dat_o;
        check(tag, d, exp);
        @(posedge clk);
        #1;
        spr_access_i   = 1'b0;
        spr_re_i       = 1'b0;
        spr_sys_mode_i = 1'b1;
    endtask

    task automatic pulse(input logic [NE-1:0] ev, input int cycles);
        @(negedge clk);
        events_i = ev;
        repeat (cycles) @(negedge clk);
        events_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        spr_access_i = 1'b0; spr_we_i = 1'b0; spr_re_i = 1'b0;
        spr_addr_i = '0; spr_dat_i = '0; spr_sys_mode_i = 1'b1; events_i = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset values
        #1 check("rst_irq", {31'b0, pcu_irq_o}, 32'd0);
        check("idle_dat", spr_dat_o, 32'd0);
        rd_chk("rst_mode0", 5'd8, 1'b1, 32'h1);
        rd_chk("rst_cntlo0", 5'd0, 1'b1, 32'h0);
        rd_chk("rst_ovf", 5'd24, 1'b1, 32'h0);
        rd_chk("rst_gctl", 5'd25, 1'b1, 32'h0);

        // Register field masking
        spr_wr(5'd25, 32'h1, 1'b1, '0);
        spr_wr(5'd15, 32'hFFFF_FFFF, 1'b1, '0);
        rd_chk("mode7_all", 5'd15, 1'b1, 32'h8000_3FFF);
        spr_wr(5'd15, 32'h0, 1'b1, '0);
        rd_chk("mode7_clr", 5'd15, 1'b1, 32'h1);
        spr_wr(5'd8, 32'h0000_000A, 1'b1, '0);
        rd_chk("mode0_rb", 5'd8, 1'b1, 32'hB);
        rd_chk("unmapped26", 5'd26, 1'b1, 32'h0);
        rd_chk("unmapped31", 5'd31, 1'b1, 32'h0);

        // Ten single events
        pulse(11'h001, 10);
        rd_chk("cnt0_10", 5'd0, 1'b1, 32'd10);
        rd_chk("cnthi0_0", 5'd16, 1'b1, 32'd0);
        rd_chk("cnt1_nomask", 5'd1, 1'b1, 32'd0);

        // Multi-event popcount: 4 events x 3 cycles
        spr_wr(5'd8, 32'h0000_007A, 1'b1, '0);
        pulse(11'h00F, 3);
        rd_chk("cnt0_22", 5'd0, 1'b1, 32'd22);

        // Overflow and interrupt on counter1
        spr_wr(5'd9, 32'h8000_000A, 1'b1, '0);
        spr_wr(5'd17, 32'h0000_FFFF, 1'b1, '0);
        spr_wr(5'd1, 32'hFFFF_FFFE, 1'b1, '0);
        pulse(11'h001, 1);
        rd_chk("ovf_pre", 5'd24, 1'b1, 32'h0);
        pulse(11'h001, 1);
        check("irq_lag", {31'b0, pcu_irq_o}, 32'd0);
        rd_chk("ovf_set", 5'd24, 1'b1, 32'h2);
        check("irq_set", {31'b0, pcu_irq_o}, 32'd1);
        rd_chk("cnt1_wrap_lo", 5'd1, 1'b1, 32'h0);
        rd_chk("cnt1_wrap_hi", 5'd17, 1'b1, 32'h0);
        spr_wr(5'd24, 32'h2, 1'b1, '0);
        check("irq_hold", {31'b0, pcu_irq_o}, 32'd1);
        @(posedge clk);
        #1 check("irq_drop", {31'b0, pcu_irq_o}, 32'd0);
        rd_chk("ovf_clr", 5'd24, 1'b1, 32'h0);

        // Freeze on overflow
        spr_wr(5'd25, 32'hFFFF_FFFF, 1'b1, '0);
        rd_chk("gctl_rb", 5'd25, 1'b1, 32'h3);
        spr_wr(5'd10, 32'h0000_0012, 1'b1, '0);
        spr_wr(5'd16, 32'h0000_FFFF, 1'b1, '0);
        spr_wr(5'd0, 32'hFFFF_FFFF, 1'b1, '0);
        pulse(11'h003, 1);
        pulse(11'h002, 3);
        rd_chk("frz_cnt2", 5'd2, 1'b1, 32'd1);
        rd_chk("frz_cnt0", 5'd0, 1'b1, 32'd1);
        rd_chk("frz_ovf", 5'd24, 1'b1, 32'h1);
        check("frz_irq_noovie", {31'b0, pcu_irq_o}, 32'd0);
        spr_wr(5'd24, 32'h1, 1'b1, '0);
        pulse(11'h002, 2);
        rd_chk("thaw_cnt2", 5'd2, 1'b1, 32'd3);
        spr_wr(5'd25, 32'h1, 1'b1, '0);

        // Coherent high/low reads across the 2^32 boundary
        spr_wr(5'd11, 32'h0000_000A, 1'b1, '0);
        spr_wr(5'd19, 32'h0, 1'b1, '0);
        spr_wr(5'd3, 32'hFFFF_FFFF, 1'b1, '0);
        rd_chk("cnt3_lo_pre", 5'd3, 1'b1, 32'hFFFF_FFFF);
        pulse(11'h001, 1);
        rd_chk("cnt3_hi_shadow", 5'd19, 1'b1, 32'h0);
        rd_chk("cnt3_lo_post", 5'd3, 1'b1, 32'h0);
        rd_chk("cnt3_hi_post", 5'd19, 1'b1, 32'h1);
        spr_wr(5'd19, 32'hABCD_1234, 1'b1, '0);
        rd_chk("cnt3_hi_write", 5'd19, 1'b1, 32'h1234);

        // User mode: writes dropped, control hidden, CISM-only counter idle
        spr_wr(5'd0, 32'h77, 1'b1, '0);
        spr_wr(5'd0, 32'h55, 1'b0, '0);
        rd_chk("user_cnt0", 5'd0, 1'b0, 32'h77);
        rd_chk("user_mode0", 5'd8, 1'b0, 32'h0);
        rd_chk("user_gctl", 5'd25, 1'b0, 32'h0);
        @(negedge clk);
        spr_sys_mode_i = 1'b0;
        pulse(11'h001, 4);
        spr_sys_mode_i = 1'b1;
        rd_chk("user_nocount", 5'd0, 1'b1, 32'h77);

        // Write beats increment; no overflow from a written wrap
        spr_wr(5'd0, 32'h5, 1'b1, 11'h001);
        rd_chk("wr_beats_inc", 5'd0, 1'b1, 32'h5);
        spr_wr(5'd17, 32'h0000_FFFF, 1'b1, '0);
        spr_wr(5'd1, 32'hFFFF_FFFF, 1'b1, '0);
        spr_wr(5'd1, 32'h0, 1'b1, 11'h001);
        rd_chk("wr_no_ovf", 5'd24, 1'b1, 32'h0);
        rd_chk("wr_cnt1", 5'd1, 1'b1, 32'h0);

        // Overflow set beats same-cycle W1C
        spr_wr(5'd1, 32'hFFFF_FFFF, 1'b1, '0);
        spr_wr(5'd24, 32'h2, 1'b1, 11'h001);
        rd_chk("set_beats_clr", 5'd24, 1'b1, 32'h2);
        spr_wr(5'd24, 32'h2, 1'b1, '0);
        rd_chk("ovf_clr2", 5'd24, 1'b1, 32'h0);

        // Reset mid-operation with a write and events in flight
        @(negedge clk);
        spr_access_i = 1'b1; spr_we_i = 1'b1; spr_addr_i = 16'd0;
        spr_dat_i = 32'h99; events_i = 11'h001; rst = 1'b1;
        @(negedge clk);
        spr_access_i = 1'b0; spr_we_i = 1'b0; spr_dat_i = '0; events_i = '0;
        rst = 1'b0;
        #1 check("rst2_irq", {31'b0, pcu_irq_o}, 32'd0);
        rd_chk("rst2_cnt0", 5'd0, 1'b1, 32'h0);
        rd_chk("rst2_mode0", 5'd8, 1'b1, 32'h1);
        rd_chk("rst2_gctl", 5'd25, 1'b1, 32'h0);
        rd_chk("rst2_cnthi3", 5'd19, 1'b1, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
